// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   state_e        : arbiter FSM states
//   owner_e        : which requester owns the current transaction
//   MAX_STREAK_DEF : default bound on consecutive LS grants while IF waits
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int MAX_STREAK_DEF = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory-port arbiter plus the LS streak counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   if_req     : fetch request present
//   ls_req     : load/store request present
//   grant      : strobe, high in the cycle the FSM latches the winner
//   winner     : combinational choice between the two requesters
//   streak     : consecutive LS grants taken while IF was waiting
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF,
    localparam int SW = $clog2(MAX_STREAK + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic          ls_req,
    input  logic          grant,
    output owner_e        winner,
    output logic [SW-1:0] streak
);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic streak_full;
    assign streak_full = (streak == STREAK_MAX);

    // LS has priority unless IF has already been passed over MAX_STREAK
    // times in a row. With no request at all the value is unused.
    always_comb begin
        winner = OWN_LS;
        if (ls_req && !(if_req && streak_full)) begin
            winner = OWN_LS;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

    // The streak only counts LS grants that actually made IF wait; any IF
    // grant, or an LS grant with no fetch pending, starts the count over.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (grant) begin
            if (winner == OWN_LS && if_req) begin
                if (!streak_full) begin
                    streak <= streak + 1'b1;
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction is in flight at a time: IDLE picks an owner, ISSUE presents
// the request until memory accepts it, WAIT holds until the response.
//
// Handshake: a requester raises *_req with its fields and holds them stable
// until the cycle *_done is high; *_req still high in the following cycle is
// a new request. On the memory side mem_req is held with stable fields until
// a cycle with mem_ready=1, then exactly one mem_rvalid cycle completes it.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   if_req, if_addr                : fetch request (read only)
//   if_rdata, if_done              : fetch data, one-cycle completion pulse
//   ls_req, ls_we, ls_addr,
//   ls_wdata, ls_be                : load/store request
//   ls_rdata, ls_done              : load data, one-cycle completion pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be              : request to memory (zero outside ISSUE)
//   mem_ready                      : memory accepts request this cycle
//   mem_rvalid, mem_rdata          : memory response (reads and writes)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    state_e        state, state_nxt;
    owner_e        owner, owner_nxt;
    owner_e        winner;
    logic          grant;
    logic [SW-1:0] streak;

    mem_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .ls_req (ls_req),
        .grant  (grant),
        .winner (winner),
        .streak (streak)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_LS;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_done   = 1'b0;
        ls_done   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    grant     = 1'b1;
                    owner_nxt = winner;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (owner == OWN_LS) begin
                    mem_we    = ls_we;
                    mem_addr  = ls_addr;
                    mem_wdata = ls_wdata;
                    mem_be    = ls_be;
                end else begin
                    // Fetch is always a full-word read.
                    mem_addr = if_addr;
                    mem_be   = '1;
                end
                if (mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (owner == OWN_LS) begin
                        ls_done = 1'b1;
                    end else begin
                        if_done = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data is passed straight through; requesters qualify it with *_done.
    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

    // The streak counter must never run past its bound.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (streak <= SW'(MAX_STREAK));
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, delayed-accept store, late
// response with a spurious rvalid, streak-bounded priority, streak clear and
// reset in WAIT. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    localparam logic [AW-1:0] IF_A = 32'h0000_0300;
    localparam logic [AW-1:0] LS_A = 32'h0000_0400;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [BW-1:0] ls_be;
    logic [DW-1:0] ls_rdata;
    logic          ls_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_STREAK (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_rdata   (ls_rdata),
        .ls_done    (ls_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold the requested lines high with a zero-wait memory and check that
    // the n grants come in the order given by ls_pat (bit i = 1 means grant i
    // goes to LS). Starts in an IDLE cycle, ends in the IDLE cycle after the
    // last done with both requests dropped.
    task automatic grant_seq(input logic if_on, input int n, input logic [15:0] ls_pat);
        int   g       = 0;
        int   cnt     = 0;
        int   budget  = 3 * n + 10;
        logic pending = 1'b0;
        logic last_ls = 1'b0;
        cyc();
        if_req     = if_on;
        if_addr    = IF_A;
        ls_req     = 1'b1;
        ls_we      = 1'b0;
        ls_addr    = LS_A;
        ls_be      = 4'hF;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        while ((g < n || pending) && cnt < budget) begin
            @(negedge clk);
            if (mem_req) begin
                last_ls = ls_pat[g];
                check("grant_order", mem_addr, ls_pat[g] ? LS_A : IF_A);
                g++;
                pending = 1'b1;
            end
            if (if_done || ls_done) begin
                check("done_owner", {if_done, ls_done}, last_ls ? 2'b01 : 2'b10);
                pending = 1'b0;
            end
            cyc();
            cnt++;
        end
        check("seq_grants", g, n);
        check("seq_pending", pending, 0);
        if_req     = 1'b0;
        ls_req     = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = '0;
        ls_wdata   = '0;
        ls_be      = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_done", if_done, 0);
        check("rst_ls_done", ls_done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);

        // Single fetch, zero wait.
        cyc();
        if_req    = 1'b1;
        if_addr   = 32'h100;
        mem_ready = 1'b1;
        @(negedge clk);
        check("fetch_c0_req", mem_req, 0);
        cyc();
        @(negedge clk);
        check("fetch_c1_req", mem_req, 1);
        check("fetch_c1_addr", mem_addr, 32'h100);
        check("fetch_c1_we", mem_we, 0);
        check("fetch_c1_be", mem_be, 4'hF);
        check("fetch_c1_done", if_done, 0);
        cyc();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("fetch_c2_if_done", if_done, 1);
        check("fetch_c2_rdata", if_rdata, 32'hDEAD_BEEF);
        check("fetch_c2_ls_done", ls_done, 0);
        check("fetch_c2_req", mem_req, 0);
        cyc();
        if_req     = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("fetch_c3_if_done", if_done, 0);

        // Store with acceptance delayed two cycles.
        cyc();
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_addr   = 32'h2004;
        ls_wdata  = 32'h1234_5678;
        ls_be     = 4'b0011;
        mem_ready = 1'b0;
        @(negedge clk);
        check("store_c0_req", mem_req, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            mem_ready = (k == 2);
            @(negedge clk);
            check("store_req", mem_req, 1);
            check("store_we", mem_we, 1);
            check("store_addr", mem_addr, 32'h2004);
            check("store_wdata", mem_wdata, 32'h1234_5678);
            check("store_be", mem_be, 4'b0011);
            check("store_early_done", ls_done, 0);
        end
        cyc();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("store_ls_done", ls_done, 1);
        check("store_if_done", if_done, 0);
        check("store_wait_req", mem_req, 0);
        cyc();
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("store_after_done", ls_done, 0);

        // Load with a response 5 cycles after acceptance, then a spurious rvalid.
        cyc();
        ls_req    = 1'b1;
        ls_addr   = 32'h40;
        ls_be     = 4'hF;
        mem_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("late_issue_req", mem_req, 1);
        check("late_issue_addr", mem_addr, 32'h40);
        for (int k = 0; k < 4; k++) begin
            cyc();
            mem_ready = 1'b0;
            @(negedge clk);
            check("late_wait_done", ls_done, 0);
        end
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        check("late_ls_done", ls_done, 1);
        check("late_ls_rdata", ls_rdata, 32'hCAFE_F00D);
        cyc();
        ls_req = 1'b0;
        @(negedge clk);
        check("spurious_ls_done", ls_done, 0);
        check("spurious_if_done", if_done, 0);
        check("spurious_req", mem_req, 0);
        cyc();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("idle_ls_done", ls_done, 0);

        // Both requesting: LS x4, IF, LS x4, IF.
        grant_seq(1'b1, 10, 16'h01EF);

        // Streak clear: 3 LS grants while IF waits, one LS grant with IF low,
        // then both again starts a fresh streak.
        grant_seq(1'b1, 3, 16'h0007);
        grant_seq(1'b0, 1, 16'h0001);
        grant_seq(1'b1, 5, 16'h000F);

        // Reset in WAIT with the streak at its bound.
        grant_seq(1'b1, 3, 16'h0007);
        cyc();
        if_req    = 1'b1;
        if_addr   = IF_A;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_addr   = LS_A;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rstw_idle_req", mem_req, 0);
        cyc();
        @(negedge clk);
        check("rstw_issue_addr", mem_addr, LS_A);
        cyc();
        mem_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("rstw_wait_done", ls_done, 0);
        cyc();
        reset      = 1'b0;
        if_req     = 1'b0;
        ls_req     = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("rstw_ls_done", ls_done, 0);
        check("rstw_if_done", if_done, 0);
        check("rstw_req", mem_req, 0);
        check("rstw_addr", mem_addr, 0);
        cyc();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rstw_idle2_req", mem_req, 0);
        grant_seq(1'b1, 5, 16'h000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
